uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- 8N1 UART transmitter: serializes one byte per request onto a single idle-high line.
- Bit period is a fixed number of system clocks.
- Sits between a byte source (ROM/FIFO sequencer) and the board TXD pin.
- Reports busy status and a one-cycle completion pulse so the source can advance to the next byte.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per UART bit (50 MHz / 9600 baud); legal range >= 2; bit counter width $clog2(CLKS_PER_BIT).
- PARITY_ODD, 0, parity sense when the optional parity feature is compiled in (0 = even, 1 = odd); ignored otherwise.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  transmit request; sampled only in IDLE.
- i_Tx_Byte  input  8  byte to send; captured in the cycle i_Tx_DV is accepted.
- o_Tx_Active  output  1  high while a frame (start..stop) is on the line.
- o_Tx_Done  output  1  one-cycle pulse after the stop bit completes.
- o_Tx_Serial  output  1  serial line, idle high.

Behaviour:
- Clocking and reset:
  - One clock domain (i_Clock); reset is synchronous and active-high (i_Reset).
  - All outputs are registered.
  - Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, state IDLE, counters 0.
- States: IDLE, START, DATA, STOP, CLEANUP.
- IDLE:
  - Line 1, Active 0, Done 0.
  - If i_Tx_DV=1 at edge T0: latch i_Tx_Byte into a shift register and go to START.
- START: from T0+1, Serial=0 and Active=1 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first; each bit is held exactly CLKS_PER_BIT cycles.
  - Bit i is driven during cycles T0+1+(i+1)*CLKS_PER_BIT .. T0+(i+2)*CLKS_PER_BIT.
- STOP: Serial=1 for CLKS_PER_BIT cycles (ends at T0+10*CLKS_PER_BIT).
- CLEANUP:
  - One cycle at T0+10*CLKS_PER_BIT+1: Done=1, Active=0, Serial=1.
  - Next state is IDLE.
  - Done is high exactly one cycle per frame.
- Throughput: earliest next acceptance at T0+10*CLKS_PER_BIT+2; minimum frame period 10*CLKS_PER_BIT+2 cycles.
- Request and data handling:
  - i_Tx_DV in any state other than IDLE is ignored (not queued).
  - A request held high continuously produces back-to-back frames at the minimum period.
  - i_Tx_Byte changes after acceptance do not affect the frame in flight.
- Reset mid-frame: at the next edge Serial=1, Active=0, Done=0, IDLE; the partial frame is abandoned and no Done pulse is produced.
- Reset has priority over i_Tx_DV in the same cycle.
- No glitches: Serial changes only on bit-period boundaries.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - Frame is 11 bits; STOP, CLEANUP and Done each shift one bit period later; minimum frame period 11*CLKS_PER_BIT+2.
- Undefined: 8N1 exactly as above; no parity logic is synthesized; PARITY_ODD has no effect.

Test Plan:
- Reset → Serial=1, Active=0, Done=0 for all cycles; i_Tx_DV pulsed during reset produces no frame.
- CLKS_PER_BIT=4, byte 0x55, DV pulse at T0:
  - Serial sequence per 4-cycle slot from T0+1: 0,1,0,1,0,1,0,1,0,1.
  - Active=1 over T0+1..T0+40; Done=1 only at T0+41.
- CLKS_PER_BIT=4, byte 0xA3:
  - Data slots 1,1,0,0,0,1,0,1.
  - Change i_Tx_Byte to 0x00 at T0+5 → waveform unchanged.
- DV held high continuously with 0x0F:
  - Frames start at T0, T0+42, T0+84.
  - Exactly one Done pulse per frame; DV asserted during a frame is not queued.
- Assert reset at T0+15 (mid DATA):
  - Serial=1 and Active=0 from T0+16; no Done pulse.
  - A new DV at T0+20 starts a clean frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0, byte 0x07:
  - Parity slot=1, stop follows; Done at T0+45 (CLKS_PER_BIT=4).
  - With PARITY_ODD=1 the parity slot=0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter.
// It serializes one byte per accepted request onto an idle-high line.
// Each bit lasts CLKS_PER_BIT system clocks.
//
// Optional feature macro: UART_TX_PARITY_EN.
//   When it is defined, a parity bit is inserted between the data and stop bits.
//   PARITY_ODD selects the parity sense (0 = even, 1 = odd).
//   When it is undefined, the frame is plain 8N1 and PARITY_ODD has no effect.
//
// Ports:
//   i_Clock     system clock; all logic runs on its rising edge
//   i_Reset     synchronous, active-high reset
//   i_Tx_DV     transmit request; sampled only in IDLE
//   i_Tx_Byte   byte to send; captured when i_Tx_DV is accepted
//   o_Tx_Active high while a frame (start..stop) is on the line
//   o_Tx_Done   one-cycle pulse after the stop bit completes
//   o_Tx_Serial serial line; idle high
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Tx_Serial
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Reject parameter values the bit timing cannot support.
  if (CLKS_PER_BIT < 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic            parity_q;
`endif

  // Frame sequencer.
  // Each output is registered and set one edge ahead of the bit it shows.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          clk_cnt     <= '0;
          bit_cnt     <= '0;
          if (i_Tx_DV) begin
            shift_q     <= i_Tx_Byte;
`ifdef UART_TX_PARITY_EN
            parity_q    <= (^i_Tx_Byte) ^ PAR_ODD;
`endif
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= shift_q[0];
            state       <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // shift_q[0] is the bit currently on the line.
        // shift_q[1] is the next data bit.
        S_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt     <= '0;
`ifdef UART_TX_PARITY_EN
              o_Tx_Serial <= parity_q;
              state       <= S_PARITY;
`else
              o_Tx_Serial <= 1'b1;
              state       <= S_STOP;
`endif
            end else begin
              bit_cnt     <= bit_cnt + 3'd1;
              o_Tx_Serial <= shift_q[1];
              shift_q     <= shift_q >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b1;
            state       <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            state       <= S_CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // Done is already high for this cycle.
        // Requests are still ignored here.
        S_CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer with CLKS_PER_BIT = 4.
// Expected line values come from the frame layout.
// The layout is start bit, data LSB first, optional parity, then stop bit.
// Each entry is indexed by the cycle offset from the accepting edge.
module tb_uart_tx_serializer;

  localparam int unsigned CPB  = 4;
  localparam int unsigned PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME_LEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic       active;
  logic       done;
  logic       serial;

  int n_cmp     = 0;
  int n_err     = 0;
  int n_frames  = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Tx_DV    (dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Active(active),
    .o_Tx_Done  (done),
    .o_Tx_Serial(serial)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line value for a frame slot.
  // Slot 0 is the start bit.
  // Slots 1..8 are the data bits.
  // Slot 9 is parity when enabled.
  // The last slot is the stop bit.
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return (^b) ^ (PODD != 0);
`endif
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " serial"}, serial, 1'b1);
    chk({tag, " active"}, active, 1'b0);
    chk({tag, " done"},   done,   1'b0);
  endtask

  // Check the outputs at cycle T0+k of a frame carrying byte b.
  task automatic check_cycle(input logic [7:0] b, input int k);
    if (k <= int'(FRAME_LEN)) begin
      chk($sformatf("serial k=%0d b=%02h", k, b), serial, exp_bit(b, (k - 1) / int'(CPB)));
      chk($sformatf("active k=%0d", k), active, 1'b1);
      chk($sformatf("done k=%0d", k),   done,   1'b0);
    end else begin
      chk($sformatf("cleanup serial k=%0d", k), serial, 1'b1);
      chk($sformatf("cleanup active k=%0d", k), active, 1'b0);
      chk($sformatf("cleanup done k=%0d", k),   done,   1'b1);
    end
  endtask

  // Send byte b and check every cycle of the frame.
  // The DUT must be idle on entry.
  // hold_dv keeps the request high throughout the frame.
  // noise randomizes the request and byte inputs during the frame.
  // At change_at, the byte input is cleared.
  // At abort_at, reset is asserted together with a new request.
  task automatic run_frame(input logic [7:0] b, input bit hold_dv, input bit noise,
                           input int change_at, input int abort_at);
    dv      = 1'b1;
    tx_byte = b;
    tick();
    if (!hold_dv) dv = 1'b0;
    for (int k = 1; k <= int'(FRAME_LEN) + 1; k++) begin
      check_cycle(b, k);
      if (k == change_at) tx_byte = 8'h00;
      if (noise && !hold_dv) begin
        dv      = 1'($urandom_range(0, 1));
        tx_byte = 8'($urandom);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        dv  = 1'b1;
        tick();
        rst = 1'b0;
        dv  = 1'b0;
        check_idle("abort");
        return;
      end
      tick();
    end
    if (!hold_dv) dv = 1'b0;
    n_frames++;
    check_idle("post-frame");
  endtask

  initial begin
    rst     = 1'b1;
    dv      = 1'b0;
    tx_byte = 8'h00;

    // The request is pulsed while reset is asserted; no frame may start.
    for (int i = 0; i < 4; i++) begin
      dv      = (i == 1);
      tx_byte = 8'hC3;
      tick();
      check_idle("reset");
    end
    rst = 1'b0;
    dv  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle");
    end

    run_frame(8'h55, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("gap");
    end

    // The byte input changes after acceptance; the frame must not change.
    run_frame(8'hA3, 1'b0, 1'b0, 5, 0);

    // A request held high gives back-to-back frames at the minimum period.
    for (int f = 0; f < 3; f++) run_frame(8'h0F, 1'b1, 1'b0, 0, 0);
    dv = 1'b0;
    tick();
    check_idle("after-hold");

    // Reset at T0+15 abandons the frame; a new request at T0+20 starts cleanly.
    run_frame(8'($urandom), 1'b0, 1'b0, 0, 15);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("post-abort");
    end
    run_frame(8'($urandom), 1'b0, 1'b0, 0, 0);

    // Random bytes, with noise on the inputs during frames and random idle gaps.
    for (int f = 0; f < 8; f++) begin
      run_frame(8'($urandom), 1'b0, 1'b1, 0, 0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick();
        check_idle("rand-gap");
      end
    end

    tick();
    n_cmp++;
    assert (done_seen === n_frames)
    else begin
      n_err++;
      $error("FAIL done_count: observed=%0d expected=%0d", done_seen, n_frames);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
